hamming_serial_rx: RTL and testbench
====================================

// Module: hamming_serial_rx
// PURPOSE
//   Receiving end of the serial Hamming(7,4) link that carries flash ADC samples.
//   Deserialises 7-bit codewords, one bit per accepted cycle, then corrects any
//   single-bit error and presents the 4-bit data word on a valid/ready output.
//   Sits between the serial line from the encoder side and the sample consumer.
//   Lets the next codeword shift in while the previous result is still held.
// PARAMETERS
//   CNT_W   16   width of the error/overflow counters (only with HAMMING_RX_STATS_EN)
// PORTS
//   clk          in   1      single clock; all state changes on the rising edge
//   rst          in   1      synchronous, active-high reset
//   parity_type  in   1      0 = even parity, 1 = odd; sampled when bit 7 is accepted
//   ser_in       in   1      serial code bit; c1 first, c7 last
//   ser_valid    in   1      ser_in is valid this cycle
//   ser_sof      in   1      with ser_valid: this bit is c1 of a new codeword
//   data_out     out  [4:1]  corrected data {c7,c6,c5,c3}
//   out_valid    out  1      data_out, err_* valid; held until out_ready
//   out_ready    in   1      consumer accepts when out_valid && out_ready
//   err_corr     out  1      a single-bit error was corrected in this word
//   err_pos      out  [2:0]  syndrome / flipped bit position (1..7); 0 = no error
//   overflow     out  1      1-cycle pulse: completed word dropped, output was busy
//   stat_clr     in   1      clears counters (ignored without HAMMING_RX_STATS_EN)
//   cnt_corr     out  [CNT_W-1:0]  saturating count of corrected words
//   cnt_ovf      out  [CNT_W-1:0]  saturating count of dropped words
// BEHAVIOUR
//   Codeword positions: p1=c1, p2=c2, d1=c3, p4=c4, d2=c5, d3=c6, d4=c7.
//   Rx FSM states: IDLE and RECV. bit_cnt runs 1..7.
//   IDLE: ser_valid && ser_sof -> store c1, bit_cnt=2, go to RECV. Bits without sof are ignored.
//   RECV: ser_valid stores bit c[bit_cnt]. If ser_valid is low, the FSM stalls and holds state.
//   RECV: accepting c7 completes the word and returns the FSM to IDLE.
//   ser_sof with ser_valid while in RECV: discard the partial word, store the new c1, bit_cnt=2.
//   Syndrome: s1=c1^c3^c5^c7^pt, s2=c2^c3^c6^c7^pt, s4=c4^c5^c6^c7^pt.
//   syndrome = {s4,s2,s1}. If nonzero, invert bit c[syndrome].
//   Latency: c7 accepted at cycle N -> out_valid=1 at N+1, with registered data_out, err_corr, err_pos.
//   Output register loads on completion only if !out_valid || out_ready.
//     Same-cycle accept and new completion: the new word is loaded and out_valid stays 1.
//   If the output register is full and not being accepted when c7 completes:
//     the new word is dropped, overflow pulses at N+1, and the held word is unchanged.
//   Uncorrectable double errors are miscorrected (Hamming(7,4) limit). No detection.
//   Reset values: out_valid=0, data_out=0, err_corr=0, err_pos=0, overflow=0,
//     counters=0, FSM=IDLE, bit_cnt=0.
//   Reset asserted mid-frame discards the partial word and any held output.
// CONFIGURATION
//   HAMMING_RX_STATS_EN defined:
//     cnt_corr increments when an err_corr word is loaded.
//     cnt_ovf increments on each overflow pulse.
//     Both counters saturate at all-ones. stat_clr clears both; stat_clr wins over an increment.
//   HAMMING_RX_STATS_EN undefined: no counter flops, cnt_corr = cnt_ovf = 0, stat_clr unused.
// STRUCTURE
//   Package hamming_pkg: position localparams (P1..D4), SYN_W=3, codeword/data typedefs,
//     function syndrome74(code, parity_type).
//   Sub-module hamming74_correct: combinational correction.
//     Inputs: code[7:1], parity_type. Outputs: data[4:1], err_pos[2:0].
//     Instantiated once, on the completed shift register.
//   Top level keeps the FSM, shift register, output register and stats.
// TESTING
//   1. Even parity, bits 1,0,1,1,0,1,0 (sof on the first)
//        -> data_out=4'b0101, err_pos=0, err_corr=0, one cycle after the 7th bit.
//   2. Same word with c5 flipped (1,0,1,1,1,1,0)
//        -> data_out=4'b0101, err_corr=1, err_pos=3'd5, cnt_corr=1.
//   3. Odd parity, bits 0,1,1,0,0,1,0 -> data_out=4'b0101, err_pos=0.
//   4. out_ready=0, send two full words
//        -> first word held, overflow pulses once, cnt_ovf=1.
//      Then raise out_ready -> first word accepted, out_valid drops.
//   5. sof after 4 bits, then a full valid word
//        -> only one output, matching the second word.
//      ser_valid gaps mid-word -> same result as with no gaps.
//   6. rst asserted after 3 bits of a word, with a word held
//        -> out_valid=0 the next cycle, all outputs zero.
//      The next full word decodes normally.

Source files
------------

// File: rtl/hamming_pkg.sv
// rtl/hamming_pkg.sv - Hamming(7,4) positions, types and syndrome helper
package hamming_pkg;

    localparam int P1 = 1;
    localparam int P2 = 2;
    localparam int D1 = 3;
    localparam int P4 = 4;
    localparam int D2 = 5;
    localparam int D3 = 6;
    localparam int D4 = 7;

    localparam int SYN_W = 3;

    typedef logic [7:1]       code_t;
    typedef logic [4:1]       data_t;
    typedef logic [SYN_W-1:0] syn_t;
    typedef logic [2:0]       bit_cnt_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RECV = 1'b1
    } rx_state_t;

    // Each check bit covers the positions whose index has that bit set;
    // odd parity is folded in by xoring parity_type into every check.
    function automatic syn_t syndrome74(input code_t code, input logic parity_type);
        logic s1, s2, s4;
        s1 = code[P1] ^ code[D1] ^ code[D2] ^ code[D4] ^ parity_type;
        s2 = code[P2] ^ code[D1] ^ code[D3] ^ code[D4] ^ parity_type;
        s4 = code[P4] ^ code[D2] ^ code[D3] ^ code[D4] ^ parity_type;
        return {s4, s2, s1};
    endfunction

endpackage

// File: rtl/hamming74_correct.sv
// rtl/hamming74_correct.sv - combinational Hamming(7,4) single-error correction
module hamming74_correct
    import hamming_pkg::*;
(
    input  code_t code,
    input  logic  parity_type,
    output data_t data,
    output syn_t  err_pos
);

    syn_t syn;

    // Only data positions are extracted, so only their flips matter here.
    always_comb begin
        syn     = syndrome74(code, parity_type);
        err_pos = syn;
        data    = {code[D4] ^ (syn == syn_t'(D4)),
                   code[D3] ^ (syn == syn_t'(D3)),
                   code[D2] ^ (syn == syn_t'(D2)),
                   code[D1] ^ (syn == syn_t'(D1))};
    end

endmodule

// File: rtl/hamming_serial_rx.sv
// rtl/hamming_serial_rx.sv - serial Hamming(7,4) receiver; optional stats via HAMMING_RX_STATS_EN
module hamming_serial_rx
    import hamming_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             parity_type,
    input  logic             ser_in,
    input  logic             ser_valid,
    input  logic             ser_sof,
    output logic [4:1]       data_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             err_corr,
    output logic [2:0]       err_pos,
    output logic             overflow,
    input  logic             stat_clr,
    output logic [CNT_W-1:0] cnt_corr,
    output logic [CNT_W-1:0] cnt_ovf
);

    rx_state_t state_q, state_d;
    bit_cnt_t  bit_cnt_q, bit_cnt_d;
    bit_cnt_t  wr_pos;
    logic      bit_we;
    logic      word_done;
    logic [6:1] shift_q;

    code_t done_code;
    data_t fix_data;
    syn_t  fix_pos;
    logic  load;
    logic  drop;

    // FSM state and bit counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    // Next state: sof always restarts a word, c7 completes it
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        bit_we    = 1'b0;
        word_done = 1'b0;
        wr_pos    = ser_sof ? bit_cnt_t'(1) : bit_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (ser_valid && ser_sof) begin
                    state_d   = ST_RECV;
                    bit_cnt_d = bit_cnt_t'(2);
                    bit_we    = 1'b1;
                end
            end
            ST_RECV: begin
                if (ser_valid) begin
                    bit_we = 1'b1;
                    if (ser_sof) begin
                        bit_cnt_d = bit_cnt_t'(2);
                    end else if (bit_cnt_q == bit_cnt_t'(7)) begin
                        word_done = 1'b1;
                        state_d   = ST_IDLE;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + bit_cnt_t'(1);
                    end
                end
            end
            default: begin
                state_d   = ST_IDLE;
                bit_cnt_d = '0;
            end
        endcase
    end

    // Shift register holds c1..c6; c7 is taken straight from the line
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q <= '0;
        end else begin
            for (int i = 1; i <= 6; i++) begin
                if (bit_we && wr_pos == bit_cnt_t'(i)) begin
                    shift_q[i] <= ser_in;
                end
            end
        end
    end

    assign done_code = {ser_in, shift_q};

    hamming74_correct u_correct (
        .code        (done_code),
        .parity_type (parity_type),
        .data        (fix_data),
        .err_pos     (fix_pos)
    );

    assign load = word_done && (!out_valid || out_ready);
    assign drop = word_done && out_valid && !out_ready;

    // Output register: new word replaces an accepted one, else is dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            data_out  <= '0;
            err_corr  <= 1'b0;
            err_pos   <= '0;
            overflow  <= 1'b0;
        end else begin
            overflow <= drop;
            if (load) begin
                out_valid <= 1'b1;
                data_out  <= fix_data;
                err_pos   <= fix_pos;
                err_corr  <= (fix_pos != '0);
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef HAMMING_RX_STATS_EN
    logic [CNT_W-1:0] cnt_corr_q;
    logic [CNT_W-1:0] cnt_ovf_q;

    // Saturating event counters; clear has priority over counting
    always_ff @(posedge clk) begin
        if (rst || stat_clr) begin
            cnt_corr_q <= '0;
            cnt_ovf_q  <= '0;
        end else begin
            if (load && fix_pos != '0 && cnt_corr_q != '1) begin
                cnt_corr_q <= cnt_corr_q + CNT_W'(1);
            end
            if (drop && cnt_ovf_q != '1) begin
                cnt_ovf_q <= cnt_ovf_q + CNT_W'(1);
            end
        end
    end

    assign cnt_corr = cnt_corr_q;
    assign cnt_ovf  = cnt_ovf_q;
`else
    logic stat_clr_unused;
    assign stat_clr_unused = stat_clr;
    assign cnt_corr = '0;
    assign cnt_ovf  = '0;
`endif

endmodule

// File: tb/tb_hamming_serial_rx.sv
// tb/tb_hamming_serial_rx.sv - self-checking bench for hamming_serial_rx
module tb_hamming_serial_rx;

`ifdef HAMMING_RX_STATS_EN
    localparam bit STATS_EN = 1'b1;
`else
    localparam bit STATS_EN = 1'b0;
`endif

    localparam logic [1:7] W_A     = 7'b1011010; // c1 first; data 0101, even
    localparam logic [1:7] W_A_C5  = 7'b1011110; // W_A with c5 flipped
    localparam logic [1:7] W_C_ODD = 7'b0110010; // data 0101, odd parity
    localparam logic [1:7] W_B     = 7'b0100101; // data 1010, even

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        parity_type = 1'b0;
    logic        ser_in = 1'b0;
    logic        ser_valid = 1'b0;
    logic        ser_sof = 1'b0;
    logic        out_ready = 1'b1;
    logic        stat_clr = 1'b0;
    logic [4:1]  data_out;
    logic        out_valid;
    logic        err_corr;
    logic [2:0]  err_pos;
    logic        overflow;
    logic [15:0] cnt_corr;
    logic [15:0] cnt_ovf;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    hamming_serial_rx #(.CNT_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .parity_type (parity_type),
        .ser_in      (ser_in),
        .ser_valid   (ser_valid),
        .ser_sof     (ser_sof),
        .data_out    (data_out),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .err_corr    (err_corr),
        .err_pos     (err_pos),
        .overflow    (overflow),
        .stat_clr    (stat_clr),
        .cnt_corr    (cnt_corr),
        .cnt_ovf     (cnt_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference decode: syndrome is the xor of the indices of all set bits
    function automatic void ref_decode(input logic [1:7] w_in, input logic pt,
                                       output logic [4:1] d, output logic [2:0] pos);
        logic [1:7] w;
        logic [2:0] s;
        w = w_in;
        s = 3'd0;
        for (int i = 1; i <= 7; i++) if (w[i]) s = s ^ 3'(i);
        if (pt) s = s ^ 3'b111;
        if (s != 3'd0) w[s] = ~w[s];
        d   = {w[7], w[6], w[5], w[3]};
        pos = s;
    endfunction

    logic       m_valid = 1'b0;
    logic [4:1] m_data  = '0;
    logic       m_corr  = 1'b0;
    logic [2:0] m_pos   = '0;
    logic       m_ovf   = 1'b0;
    int         m_cc    = 0;
    int         m_co    = 0;
    int         m_n     = 0;
    logic [1:7] m_w     = '0;

    always begin
        logic       done;
        logic [4:1] d;
        logic [2:0] p;
        @(posedge clk);
        if (rst) begin
            m_valid = 1'b0; m_data = '0; m_corr = 1'b0; m_pos = '0; m_ovf = 1'b0;
            m_cc = 0; m_co = 0; m_n = 0;
        end else begin
            done = 1'b0;
            if (ser_valid) begin
                if (ser_sof) begin
                    m_w = '0; m_w[1] = ser_in; m_n = 1;
                end else if (m_n > 0) begin
                    m_n++;
                    m_w[m_n] = ser_in;
                    if (m_n == 7) begin done = 1'b1; m_n = 0; end
                end
            end
            m_ovf = 1'b0;
            if (done) begin
                ref_decode(m_w, parity_type, d, p);
                if (!m_valid || out_ready) begin
                    m_valid = 1'b1; m_data = d; m_pos = p; m_corr = (p != 3'd0);
                    if (p != 3'd0 && m_cc < 65535) m_cc++;
                end else begin
                    m_ovf = 1'b1;
                    if (m_co < 65535) m_co++;
                end
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
            if (stat_clr) begin m_cc = 0; m_co = 0; end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cmp_out_valid", 32'(out_valid), 32'(m_valid));
            if (m_valid) begin
                check("cmp_data_out", 32'(data_out), 32'(m_data));
                check("cmp_err_corr", 32'(err_corr), 32'(m_corr));
                check("cmp_err_pos", 32'(err_pos), 32'(m_pos));
            end
            check("cmp_overflow", 32'(overflow), 32'(m_ovf));
            check("cmp_cnt_corr", 32'(cnt_corr), STATS_EN ? 32'(m_cc) : 32'd0);
            check("cmp_cnt_ovf", 32'(cnt_ovf), STATS_EN ? 32'(m_co) : 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends the first n bits of w (c1 carries sof); gap idle cycles between bits
    task automatic send_bits(input logic [1:7] w, input int n, input int gap, input bit rdy_last);
        for (int i = 1; i <= n; i++) begin
            if (rdy_last && i == 7) out_ready = 1'b1;
            ser_in    = w[i];
            ser_sof   = (i == 1);
            ser_valid = 1'b1;
            tick();
            ser_valid = 1'b0;
            ser_sof   = 1'b0;
            if (i < n) repeat (gap) tick();
        end
    endtask

    initial begin
        tick();
        cmp_en = 1'b1;
        tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_data_out", 32'(data_out), 32'd0);
        check("rst_err_pos", 32'(err_pos), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_cnt_corr", 32'(cnt_corr), 32'd0);
        rst = 1'b0;
        tick();

        // 1: clean even word
        send_bits(W_A, 7, 0, 1'b0);
        check("t1_valid", 32'(out_valid), 32'd1);
        check("t1_data", 32'(data_out), 32'b0101);
        check("t1_corr", 32'(err_corr), 32'd0);
        check("t1_pos", 32'(err_pos), 32'd0);
        repeat (2) tick();

        // 2: c5 flipped
        send_bits(W_A_C5, 7, 0, 1'b0);
        check("t2_data", 32'(data_out), 32'b0101);
        check("t2_corr", 32'(err_corr), 32'd1);
        check("t2_pos", 32'(err_pos), 32'd5);
        check("t2_cnt_corr", 32'(cnt_corr), STATS_EN ? 32'd1 : 32'd0);
        repeat (2) tick();

        // 3: odd parity
        parity_type = 1'b1;
        send_bits(W_C_ODD, 7, 0, 1'b0);
        check("t3_data", 32'(data_out), 32'b0101);
        check("t3_pos", 32'(err_pos), 32'd0);
        tick();
        parity_type = 1'b0;
        tick();

        // 4: output busy, second word dropped
        out_ready = 1'b0;
        send_bits(W_A, 7, 0, 1'b0);
        send_bits(W_B, 7, 0, 1'b0);
        check("t4_ovf_pulse", 32'(overflow), 32'd1);
        check("t4_held_data", 32'(data_out), 32'b0101);
        check("t4_cnt_ovf", 32'(cnt_ovf), STATS_EN ? 32'd1 : 32'd0);
        tick();
        check("t4_ovf_end", 32'(overflow), 32'd0);
        out_ready = 1'b1;
        tick();
        check("t4_accepted", 32'(out_valid), 32'd0);

        // 7: accept and new completion in the same cycle
        out_ready = 1'b0;
        send_bits(W_A, 7, 0, 1'b0);
        send_bits(W_B, 7, 0, 1'b1);
        check("t7_valid", 32'(out_valid), 32'd1);
        check("t7_data", 32'(data_out), 32'b1010);
        check("t7_no_ovf", 32'(overflow), 32'd0);
        repeat (2) tick();

        // counter clear
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        check("clr_cnt_corr", 32'(cnt_corr), 32'd0);
        check("clr_cnt_ovf", 32'(cnt_ovf), 32'd0);

        // 5: stray bits in idle, restart after 4 bits, then gaps
        ser_valid = 1'b1; ser_in = 1'b1;
        repeat (3) tick();
        ser_valid = 1'b0;
        send_bits(W_A, 4, 0, 1'b0);
        send_bits(W_B, 7, 0, 1'b0);
        check("t5_data", 32'(data_out), 32'b1010);
        repeat (2) tick();
        send_bits(W_A, 7, 2, 1'b0);
        check("t5_gap_data", 32'(data_out), 32'b0101);
        check("t5_gap_pos", 32'(err_pos), 32'd0);
        repeat (2) tick();

        // 6: reset mid-frame with a word held
        out_ready = 1'b0;
        send_bits(W_A, 7, 0, 1'b0);
        send_bits(W_B, 3, 0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_valid", 32'(out_valid), 32'd0);
        check("t6_data", 32'(data_out), 32'd0);
        check("t6_corr", 32'(err_corr), 32'd0);
        out_ready = 1'b1;
        send_bits(W_B, 7, 0, 1'b0);
        check("t6_after_data", 32'(data_out), 32'b1010);
        check("t6_after_valid", 32'(out_valid), 32'd1);
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
